// File: rtl/blk_mode_chain_pkg.sv
// rtl/blk_mode_chain_pkg.sv - shared types and defaults for the block-cipher mode sequencer
package blk_mode_pkg;

  localparam int DEF_BLK_W = 128;
  localparam int DEF_CTR_W = 32;

  typedef enum logic [1:0] {
    MODE_ECB  = 2'b00,
    MODE_CBC  = 2'b01,
    MODE_CTR  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_IN,
    ST_WAIT_CORE,
    ST_OUT
  } state_e;

endpackage

// File: rtl/blk_mode_chain_if.sv
// rtl/blk_mode_chain_if.sv - stream source/sink and cipher-core handshake bundle
interface blk_mode_chain_if #(
  parameter int BLK_W = 128
) ();

  logic [BLK_W-1:0] s_tdata;
  logic             s_tvalid;
  logic             s_tlast;
  logic             s_tready;

  logic [BLK_W-1:0] m_tdata;
  logic             m_tvalid;
  logic             m_tlast;
  logic             m_tready;

  logic             core_start;
  logic             core_dec;
  logic [BLK_W-1:0] core_din;
  logic [BLK_W-1:0] core_dout;
  logic             core_done;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_tready, core_dout, core_done,
    output s_tready, m_tdata, m_tvalid, m_tlast, core_start, core_dec, core_din
  );

  modport master (
    output s_tdata, s_tvalid, s_tlast, m_tready, core_dout, core_done,
    input  s_tready, m_tdata, m_tvalid, m_tlast, core_start, core_dec, core_din
  );

endinterface

// File: rtl/blk_mode_chain_ctr_inc.sv
// rtl/blk_mode_chain_ctr_inc.sv - wrap-around increment of the low CTR_W bits of a block
module blk_ctr_inc #(
  parameter int BLK_W = 128,
  parameter int CTR_W = 32
) (
  input  logic [BLK_W-1:0] din,
  output logic [BLK_W-1:0] dout
);

  generate
    if (CTR_W >= BLK_W) begin : g_full
      assign dout = din + BLK_W'(1);
    end else begin : g_part
      assign dout = {din[BLK_W-1:CTR_W], din[CTR_W-1:0] + CTR_W'(1)};
    end
  endgenerate

endmodule

// File: rtl/blk_mode_chain.sv
// rtl/blk_mode_chain.sv - ECB/CBC/CTR sequencer between a block stream and an external cipher core
module blk_mode_chain
  import blk_mode_pkg::*;
#(
  parameter int BLK_W = DEF_BLK_W,
  parameter int CTR_W = DEF_CTR_W
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic [1:0]       cfg_mode,
  input  logic             cfg_dec,
  input  logic [BLK_W-1:0] cfg_iv,
  input  logic             cfg_load,
  output logic             busy,
  output logic             err,
  blk_mode_chain_if.slave  bus
);

  state_e           state, state_nxt;
  mode_e            mode_q;
  logic             dec_q;
  logic [BLK_W-1:0] chain_q;
  logic [BLK_W-1:0] chain_inc;
  logic [BLK_W-1:0] data_q;
  logic [BLK_W-1:0] din_q;
  logic [BLK_W-1:0] out_q;
  logic             last_q;
  logic             mlast_q;
  logic             start_q;
  logic             cdec_q;
  logic             err_q;
  logic             in_hs;
  logic             out_hs;
  logic             core_hit;
  logic             load_ok;
  logic             s_ready_c;
  logic             m_valid_c;

  blk_ctr_inc #(.BLK_W(BLK_W), .CTR_W(CTR_W)) u_ctr_inc (
    .din  (chain_q),
    .dout (chain_inc)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_ready_c = 1'b0;
    m_valid_c = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (cfg_load && cfg_mode != MODE_RSVD) state_nxt = ST_WAIT_IN;
      end
      ST_WAIT_IN: begin
        s_ready_c = 1'b1;
        if (bus.s_tvalid) state_nxt = ST_WAIT_CORE;
      end
      ST_WAIT_CORE: begin
        if (bus.core_done) state_nxt = ST_OUT;
      end
      ST_OUT: begin
        m_valid_c = 1'b1;
        if (bus.m_tready) state_nxt = last_q ? ST_IDLE : ST_WAIT_IN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign in_hs    = s_ready_c && bus.s_tvalid;
  assign out_hs   = m_valid_c && bus.m_tready;
  assign core_hit = (state == ST_WAIT_CORE) && bus.core_done;
  assign load_ok  = (state == ST_IDLE) && cfg_load && (cfg_mode != MODE_RSVD);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      mode_q  <= MODE_ECB;
      dec_q   <= 1'b0;
      chain_q <= '0;
      data_q  <= '0;
      din_q   <= '0;
      out_q   <= '0;
      last_q  <= 1'b0;
      mlast_q <= 1'b0;
      start_q <= 1'b0;
      cdec_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      start_q <= in_hs;
      if (load_ok) begin
        mode_q  <= mode_e'(cfg_mode);
        dec_q   <= cfg_dec;
        chain_q <= cfg_iv;
      end
      // The core input is fixed at capture time and held until the next block.
      if (in_hs) begin
        data_q <= bus.s_tdata;
        last_q <= bus.s_tlast;
        cdec_q <= dec_q && (mode_q != MODE_CTR);
        case (mode_q)
          MODE_CBC: din_q <= dec_q ? bus.s_tdata : (bus.s_tdata ^ chain_q);
          MODE_CTR: din_q <= chain_q;
          default:  din_q <= bus.s_tdata;
        endcase
      end
      if (core_hit) begin
        mlast_q <= last_q;
        case (mode_q)
          MODE_CBC: begin
            if (dec_q) begin
              out_q   <= bus.core_dout ^ chain_q;
              chain_q <= data_q;
            end else begin
              out_q   <= bus.core_dout;
              chain_q <= bus.core_dout;
            end
          end
          MODE_CTR: begin
            out_q   <= bus.core_dout ^ data_q;
            chain_q <= chain_inc;
          end
          default: out_q <= bus.core_dout;
        endcase
      end
      if (out_hs && last_q) chain_q <= '0;
      if (load_ok) err_q <= 1'b0;
      if (cfg_load && !load_ok) err_q <= 1'b1;
      if (bus.core_done && state != ST_WAIT_CORE) err_q <= 1'b1;
    end
  end

  assign bus.s_tready   = s_ready_c;
  assign bus.m_tvalid   = m_valid_c;
  assign bus.m_tdata    = out_q;
  assign bus.m_tlast    = mlast_q;
  assign bus.core_start = start_q;
  assign bus.core_dec   = cdec_q;
  assign bus.core_din   = din_q;
  assign err            = err_q;

endmodule

// File: tb/tb_blk_mode_chain.sv
// tb/tb_blk_mode_chain.sv - self-checking bench for blk_mode_chain with an XOR stub cipher core
module tb_blk_mode_chain;

  localparam logic [127:0] A = {16{8'hA5}};

  typedef struct {
    logic [1:0]   mode;
    logic         dec;
    logic [127:0] iv;
    logic [127:0] p0;
    logic [127:0] p1;
    logic [127:0] e0;
    logic [127:0] e1;
    logic         edec;
  } vec_t;

  logic         ACLK = 1'b0;
  logic         ARESETN = 1'b0;
  logic [1:0]   cfg_mode = 2'b00;
  logic         cfg_dec = 1'b0;
  logic [127:0] cfg_iv = '0;
  logic         cfg_load = 1'b0;
  logic         busy;
  logic         err;
  logic         inj_done = 1'b0;
  logic [2:0]   sr;

  int total = 0;
  int bad = 0;
  logic [128:0] exp_q[$];
  vec_t vecs[6];

  blk_mode_chain_if #(.BLK_W(128)) bus ();

  blk_mode_chain #(.BLK_W(128), .CTR_W(32)) dut (
    .ACLK     (ACLK),
    .ARESETN  (ARESETN),
    .cfg_mode (cfg_mode),
    .cfg_dec  (cfg_dec),
    .cfg_iv   (cfg_iv),
    .cfg_load (cfg_load),
    .busy     (busy),
    .err      (err),
    .bus      (bus)
  );

  always #5 ACLK = ~ACLK;

  // Stub core: F(x) = x ^ A, done three cycles after start.
  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) sr <= '0;
    else          sr <= {sr[1:0], bus.core_start};
  end
  assign bus.core_done = sr[2] | inj_done;
  assign bus.core_dout = bus.core_din ^ A;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_load(input logic [1:0] m, input logic d, input logic [127:0] iv);
    cfg_mode = m;
    cfg_dec  = d;
    cfg_iv   = iv;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    cfg_mode = 2'b00;
    cfg_dec  = 1'b0;
    cfg_iv   = '0;
  endtask

  task automatic xfer(input logic [127:0] d, input logic l, input logic [127:0] e, input logic edec);
    int n;
    logic [128:0] ex;
    bus.s_tdata  = d;
    bus.s_tvalid = 1'b1;
    bus.s_tlast  = l;
    n = 0;
    while (!bus.s_tready && n < 50) begin
      tick();
      n++;
    end
    chki("s_tready_wait", int'(n < 50), 1);
    exp_q.push_back({l, e});
    tick();
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
    bus.s_tdata  = '0;
    chki("core_start", int'(bus.core_start), 1);
    chki("core_dec", int'(bus.core_dec), int'(edec));
    n = 1;
    while (!bus.m_tvalid && n < 50) begin
      tick();
      n++;
    end
    chki("latency", n, 5);
    ex = exp_q.pop_front();
    chkw("m_tdata", bus.m_tdata, ex[127:0]);
    chki("m_tlast", int'(bus.m_tlast), int'(ex[128]));
    tick();
  endtask

  initial begin
    logic [127:0] snap;
    int n;

    vecs[0] = '{2'b00, 1'b0, 128'h0, 128'h0, 128'h0123_4567_89ab_cdef_0011_2233_4455_6677,
                A, 128'h0123_4567_89ab_cdef_0011_2233_4455_6677 ^ A, 1'b0};
    vecs[1] = '{2'b00, 1'b1, 128'h0, 128'hdead_beef, A, 128'hdead_beef ^ A, 128'h0, 1'b1};
    vecs[2] = '{2'b01, 1'b0, 128'h1, 128'h0, 128'h0, A ^ 128'h1, 128'h1, 1'b0};
    vecs[3] = '{2'b01, 1'b1, 128'h1, A ^ 128'h1, 128'h1, 128'h0, 128'h0, 1'b1};
    vecs[4] = '{2'b10, 1'b0, 128'hFFFF_FFFF, 128'h0, 128'h0, 128'hFFFF_FFFF ^ A, A, 1'b0};
    vecs[5] = '{2'b10, 1'b1, {96'h1234_5678_9abc_def0_1111_2222, 32'hFFFF_FFFF}, 128'h5, 128'hF0,
                {96'h1234_5678_9abc_def0_1111_2222, 32'hFFFF_FFFF} ^ A ^ 128'h5,
                {96'h1234_5678_9abc_def0_1111_2222, 32'h0} ^ A ^ 128'hF0, 1'b0};

    bus.s_tdata  = '0;
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
    bus.m_tready = 1'b1;

    tick();
    tick();
    chki("rst_busy", int'(busy), 0);
    chki("rst_err", int'(err), 0);
    chki("rst_s_tready", int'(bus.s_tready), 0);
    chki("rst_m_tvalid", int'(bus.m_tvalid), 0);
    chki("rst_core_start", int'(bus.core_start), 0);
    chkw("rst_m_tdata", bus.m_tdata, '0);
    ARESETN = 1'b1;
    tick();

    do_load(2'b00, 1'b0, '0);
    chki("ecb_busy", int'(busy), 1);
    xfer('0, 1'b1, A, 1'b0);
    chki("ecb_idle_after", int'(busy), 0);

    for (int i = 0; i < 6; i++) begin
      do_load(vecs[i].mode, vecs[i].dec, vecs[i].iv);
      xfer(vecs[i].p0, 1'b0, vecs[i].e0, vecs[i].edec);
      xfer(vecs[i].p1, 1'b1, vecs[i].e1, vecs[i].edec);
      chki("vec_idle", int'(busy), 0);
    end

    do_load(2'b00, 1'b0, '0);
    bus.s_tdata  = 128'h5;
    bus.s_tvalid = 1'b1;
    bus.s_tlast  = 1'b1;
    tick();
    bus.s_tvalid = 1'b0;
    bus.m_tready = 1'b0;
    n = 0;
    while (!bus.m_tvalid && n < 50) begin
      tick();
      n++;
    end
    chki("bp_wait", int'(n < 50), 1);
    snap = bus.m_tdata;
    chkw("bp_data", snap, 128'h5 ^ A);
    for (int i = 0; i < 10; i++) begin
      tick();
      chkw("bp_stable", bus.m_tdata, snap);
      chki("bp_valid", int'(bus.m_tvalid), 1);
      chki("bp_s_tready", int'(bus.s_tready), 0);
    end
    bus.m_tready = 1'b1;
    tick();
    chki("bp_idle", int'(busy), 0);

    do_load(2'b00, 1'b0, '0);
    bus.s_tdata  = 128'h77;
    bus.s_tvalid = 1'b1;
    bus.s_tlast  = 1'b0;
    tick();
    bus.s_tvalid = 1'b0;
    tick();
    ARESETN = 1'b0;
    #1;
    chki("ar_busy", int'(busy), 0);
    chki("ar_m_tvalid", int'(bus.m_tvalid), 0);
    chki("ar_core_start", int'(bus.core_start), 0);
    chki("ar_core_dec", int'(bus.core_dec), 0);
    chkw("ar_core_din", bus.core_din, '0);
    chkw("ar_m_tdata", bus.m_tdata, '0);
    tick();
    ARESETN = 1'b1;
    tick();

    do_load(2'b11, 1'b0, '0);
    chki("rsvd_err", int'(err), 1);
    chki("rsvd_busy", int'(busy), 0);
    do_load(2'b00, 1'b0, '0);
    chki("load_clr_err", int'(err), 0);
    xfer(128'h3, 1'b1, 128'h3 ^ A, 1'b0);
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    chki("idle_done_err", int'(err), 1);
    chki("idle_done_busy", int'(busy), 0);
    do_load(2'b00, 1'b0, '0);
    chki("load_clr_err2", int'(err), 0);
    cfg_mode = 2'b01;
    cfg_iv   = 128'hFF;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    cfg_mode = 2'b00;
    cfg_iv   = '0;
    chki("busy_load_err", int'(err), 1);
    xfer('0, 1'b1, A, 1'b0);
    chki("busy_load_idle", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
